// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl
// Interrupt-request front end for an 8-to-3 priority encoding path.
// Rising edges on req are captured into a pending register. The
// highest-priority pending source that is also enabled in mask (bit 7
// highest) is presented as a 3-bit index over a valid/ready handshake.
// The presented pending bit is cleared when the consumer accepts it.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   req[7:0]   level request lines; each 0->1 transition is one event
//   mask[7:0]  per-source enable for selection (pending still latches)
//   pend_clr   one-cycle software clear of pending bits
//   irq_ready  consumer accepts irq_id when high together with irq_valid
//   irq_valid  irq_id is valid and held stable until accepted
//   irq_id     index of the presented source
//   pending    current pending register
//   overrun    sticky: an edge arrived on a bit that was already pending
//   ovr_clr    clears the corresponding overrun bits
//
// Build option: define IRQ_SYNC_EN to pass req through a two-flop
// synchronizer before edge detection (req asynchronous to clk). This
// adds two cycles of latency from req to irq_valid.

module irq_pending_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic [7:0] pend_clr,
  input  logic       irq_ready,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  output logic [7:0] pending,
  output logic [7:0] overrun,
  input  logic [7:0] ovr_clr
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t     state_reg;
  logic       valid_reg;
  logic [2:0] id_reg;
  logic [7:0] req_s;
  logic [7:0] req_q_reg;
  logic [7:0] pend_reg;
  logic [7:0] pend_next;
  logic [7:0] ovr_reg;
  logic [7:0] ovr_next;
  logic [7:0] edge_v;
  logic [7:0] clear_v;
  logic [7:0] cand;
  logic [2:0] sel;
  logic       accept;

`ifdef IRQ_SYNC_EN
  logic [7:0] sync1_reg;
  logic [7:0] sync2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= req;
      sync2_reg <= sync1_reg;
    end
  end

  assign req_s = sync2_reg;
`else
  assign req_s = req;
`endif

  assign edge_v = req_s & ~req_q_reg;
  assign accept = valid_reg & irq_ready;
  assign cand   = pend_reg & mask;

  // Per-bit pending / overrun rules; a new edge always wins over a clear.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      assign clear_v[gi]   = pend_clr[gi] | (accept & (id_reg == 3'(gi)));
      assign pend_next[gi] = (pend_reg[gi] & ~clear_v[gi]) | edge_v[gi];
      assign ovr_next[gi]  = (ovr_reg[gi] & ~ovr_clr[gi]) |
                             (edge_v[gi] & pend_reg[gi] & ~clear_v[gi]);
    end
  endgenerate

  // Ascending scan so the highest enabled pending index is kept.
  always_comb begin
    sel = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (cand[i]) sel = 3'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q_reg <= '0;
      pend_reg  <= '0;
      ovr_reg   <= '0;
    end else begin
      req_q_reg <= req_s;
      pend_reg  <= pend_next;
      ovr_reg   <= ovr_next;
    end
  end

  // Presentation FSM. Once PRESENT, irq_id is frozen until accepted,
  // regardless of later mask changes, clears or higher-priority arrivals.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      valid_reg <= 1'b0;
      id_reg    <= 3'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|cand) begin
            id_reg    <= sel;
            valid_reg <= 1'b1;
            state_reg <= PRESENT;
          end
        end
        PRESENT: begin
          if (accept) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          valid_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign irq_valid = valid_reg;
  assign irq_id    = id_reg;
  assign pending   = pend_reg;
  assign overrun   = ovr_reg;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Testbench for irq_pending_ctrl: directed scenarios followed by random
// traffic, all checked cycle by cycle against a behavioural model.
module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req, mask, pend_clr, ovr_clr;
  logic       irq_ready;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending, overrun;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  logic [7:0] m_prev, m_s1, m_s2, m_pend, m_ovr;
  logic       m_valid;
  int         m_id;

  irq_pending_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .pend_clr(pend_clr),
    .irq_ready(irq_ready), .irq_valid(irq_valid), .irq_id(irq_id),
    .pending(pending), .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = '0; m_s1 = '0; m_s2 = '0; m_pend = '0; m_ovr = '0;
    m_valid = 1'b0; m_id = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs in effect.
  task automatic model_step();
    logic [7:0] samp, edges, np, no, avail;
    logic       acc, clr;
`ifdef IRQ_SYNC_EN
    samp = m_s2;
    m_s2 = m_s1;
    m_s1 = req;
`else
    samp = req;
`endif
    edges = samp & ~m_prev;
    acc   = m_valid && irq_ready;
    for (int i = 0; i < 8; i++) begin
      clr   = pend_clr[i] || (acc && m_id == i);
      np[i] = (m_pend[i] && !clr) || edges[i];
      no[i] = (m_ovr[i] && !ovr_clr[i]) || (edges[i] && m_pend[i] && !clr);
    end
    avail = m_pend & mask;
    if (m_valid) begin
      if (acc) m_valid = 1'b0;
    end else if (avail != 0) begin
      m_valid = 1'b1;
      for (int i = 7; i >= 0; i--) begin
        if (avail[i]) begin
          m_id = i;
          break;
        end
      end
    end
    m_prev = samp;
    m_pend = np;
    m_ovr  = no;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, 8'(irq_valid), 8'(m_valid));
    if (m_valid) check({tag, ".id"}, 8'(irq_id), 8'(m_id));
    check({tag, ".pending"}, pending, m_pend);
    check({tag, ".overrun"}, overrun, m_ovr);
  endtask

  // Called at a negedge: apply inputs, pass one rising edge, then compare.
  task automatic cycle(input logic [7:0] r, input logic [7:0] m,
                       input logic [7:0] pc, input logic rdy,
                       input logic [7:0] oc, input string tag);
    req = r; mask = m; pend_clr = pc; irq_ready = rdy; ovr_clr = oc;
    @(posedge clk);
    model_step();
    @(negedge clk);
    $display("%s: req=%02h mask=%02h pclr=%02h rdy=%0d oclr=%02h -> valid=%0d id=%0d pend=%02h ovr=%02h",
             tag, r, m, pc, rdy, oc, irq_valid, irq_id, pending, overrun);
    compare_all(tag);
  endtask

  task automatic wait_valid(input string tag, input logic [7:0] m);
    int k = 0;
    while (!m_valid && k < 12) begin
      cycle(8'h00, m, 8'h00, 1'b0, 8'h00, tag);
      k++;
    end
    if (!m_valid) check({tag, ".timeout"}, 8'd0, 8'd1);
  endtask

  initial begin
    int lat;
    logic [7:0] r;
    rst = 1'b1; req = '0; mask = 8'hFF; pend_clr = '0; ovr_clr = '0; irq_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all("reset");

    // single event latency and service
    lat = 0;
    cycle(8'h01, 8'hFF, 8'h00, 1'b0, 8'h00, "lat");
    lat++;
    while (!irq_valid && lat < 10) begin
      cycle(8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, "lat");
      lat++;
    end
`ifdef IRQ_SYNC_EN
    check("latency", 8'(lat), 8'd4);
`else
    check("latency", 8'(lat), 8'd2);
`endif
    check("lat.id", 8'(irq_id), 8'd0);
    cycle(8'h00, 8'hFF, 8'h00, 1'b1, 8'h00, "svc");
    check("svc.pend", pending, 8'h00);

    // two sources together, ready held: 2 then 0
    cycle(8'h05, 8'hFF, 8'h00, 1'b1, 8'h00, "pair");
    for (int i = 0; i < 8; i++) cycle(8'h05, 8'hFF, 8'h00, 1'b1, 8'h00, "pair");
    cycle(8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, "pair");

    // presented id held while higher priority arrives
    cycle(8'h02, 8'hFF, 8'h00, 1'b0, 8'h00, "hold");
    wait_valid("hold", 8'hFF);
    check("hold.id1", 8'(irq_id), 8'd1);
    for (int i = 0; i < 4; i++) cycle(8'h40, 8'hFF, 8'h00, 1'b0, 8'h00, "hold");
    check("hold.still1", 8'(irq_id), 8'd1);
    cycle(8'h00, 8'hFF, 8'h00, 1'b1, 8'h00, "hold");
    cycle(8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, "hold");
    check("hold.next6", 8'(irq_id), 8'd6);
    cycle(8'h00, 8'hFF, 8'h00, 1'b1, 8'h00, "hold");

    // masked source latches but is not presented until enabled
    cycle(8'h80, 8'h0F, 8'h00, 1'b0, 8'h00, "mask");
    for (int i = 0; i < 4; i++) cycle(8'h00, 8'h0F, 8'h00, 1'b0, 8'h00, "mask");
    check("mask.pend", pending, 8'h80);
    check("mask.novalid", 8'(irq_valid), 8'd0);
    cycle(8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, "mask");
    check("mask.id7", 8'(irq_id), 8'd7);
    cycle(8'h00, 8'hFF, 8'h00, 1'b1, 8'h00, "mask");

    // overrun on second edge while pending, edge on accept, ovr_clr
    cycle(8'h08, 8'h00, 8'h00, 1'b0, 8'h00, "ovr");
    cycle(8'h00, 8'h00, 8'h00, 1'b0, 8'h00, "ovr");
    for (int i = 0; i < 4; i++) cycle(8'h08, 8'h00, 8'h00, 1'b0, 8'h00, "ovr");
    check("ovr.set", overrun, 8'h08);
    cycle(8'h00, 8'h00, 8'h00, 1'b0, 8'h08, "ovr");
    check("ovr.clr", overrun, 8'h00);
    wait_valid("ovr", 8'hFF);
    // lower req now, raise it so the sampled edge lands on the accept cycle
`ifdef IRQ_SYNC_EN
    cycle(8'h08, 8'hFF, 8'h00, 1'b0, 8'h00, "ovr");
    cycle(8'h08, 8'hFF, 8'h00, 1'b0, 8'h00, "ovr");
`endif
    cycle(8'h08, 8'hFF, 8'h00, 1'b1, 8'h00, "ovr");
    check("ovr.acc_pend", pending, 8'h08);
    check("ovr.acc_ovr", overrun, 8'h00);
    for (int i = 0; i < 6; i++) cycle(8'h00, 8'hFF, 8'hFF, 1'b1, 8'hFF, "ovr");

    // asynchronous reset while presenting
    cycle(8'h10, 8'hFF, 8'h00, 1'b0, 8'h00, "rst");
    wait_valid("rst", 8'hFF);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst.valid", 8'(irq_valid), 8'd0);
    check("rst.pend", pending, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    compare_all("rst.after");

    // random traffic
    r = 8'h00;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) r = r ^ (8'($urandom) & 8'($urandom));
      cycle(r,
            ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF,
            ($urandom_range(0, 7) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00,
            "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
